// File: rtl/map_table_ckpt_pkg.sv
// Shared types and sizing for the checkpointed rename map table.
// Lane count and checkpoint depth are exposed as macros for the surrounding dispatch code.
`ifndef WAY
`define WAY 3
`endif
`ifndef NUM_CKPT
`define NUM_CKPT 4
`endif

package sys_defs;
  localparam int WAY       = `WAY;
  localparam int ARCH_REGS = 32;
  localparam int PHY_REGS  = 64;
  localparam int CDB_WIDTH = 3;
  localparam int NUM_CKPT  = `NUM_CKPT;
  localparam int PRW       = $clog2(PHY_REGS);
  localparam int ARW       = $clog2(ARCH_REGS);
  localparam int CKW       = $clog2(NUM_CKPT);
  localparam int LANE_W    = $clog2(WAY);
  localparam int CNTW      = CKW + 1;

  typedef logic [PRW-1:0] phy_reg_idx_t;
  typedef logic [ARW-1:0] arch_reg_idx_t;
  typedef logic [CKW-1:0] ckpt_idx_t;

  typedef struct packed {
    logic          valid;
    arch_reg_idx_t rs1;
    arch_reg_idx_t rs2;
    arch_reg_idx_t rd;
  } map_table_input_t;

  typedef struct packed {
    phy_reg_idx_t rs1_tag;
    logic         rs1_rdy;
    phy_reg_idx_t rs2_tag;
    logic         rs2_rdy;
  } map_table_output_t;

  function automatic ckpt_idx_t ckpt_inc(ckpt_idx_t p);
    return (int'(p) == NUM_CKPT - 1) ? '0 : p + ckpt_idx_t'(1);
  endfunction

  // Number of slots from 'from' forward to 'to', exclusive of 'to', modulo the ring size.
  function automatic logic [CNTW-1:0] ckpt_dist(ckpt_idx_t from, ckpt_idx_t to);
    if (to >= from) return {1'b0, to} - {1'b0, from};
    else            return {1'b0, to} + CNTW'(NUM_CKPT) - {1'b0, from};
  endfunction
endpackage

// File: rtl/map_table_ckpt_ctrl.sv
// Checkpoint slot ring: head/tail/count bookkeeping, allocation grant and
// recovery truncation of younger slots.
module map_ckpt_ctrl
  import sys_defs::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      i_alloc_req,
  input  logic      i_retire,
  input  logic      i_recover,
  input  ckpt_idx_t i_recover_id,
  output ckpt_idx_t o_alloc_id,
  output logic      o_full,
  output logic      o_alloc_ok
);
  ckpt_idx_t       r_head, r_tail;
  logic [CNTW-1:0] r_count;

  logic            w_retire_ok;
  ckpt_idx_t       w_head_nxt, w_tail_nxt;
  logic [CNTW-1:0] w_cnt_ret, w_cnt_nxt;

  assign o_full     = (r_count == CNTW'(NUM_CKPT));
  assign o_alloc_id = r_tail;
  assign o_alloc_ok = i_alloc_req && !o_full && !i_recover;

  // Retire is applied before recovery so the recomputed count is measured from the new head.
  always_comb begin
    w_retire_ok = i_retire && (r_count != '0);
    w_head_nxt  = w_retire_ok ? ckpt_inc(r_head) : r_head;
    w_cnt_ret   = r_count - CNTW'(w_retire_ok);
    w_tail_nxt  = r_tail;
    w_cnt_nxt   = w_cnt_ret;
    if (i_recover) begin
      w_tail_nxt = ckpt_inc(i_recover_id);
      w_cnt_nxt  = ckpt_dist(w_head_nxt, i_recover_id) + CNTW'(1);
    end else if (o_alloc_ok) begin
      w_tail_nxt = ckpt_inc(r_tail);
      w_cnt_nxt  = w_cnt_ret + CNTW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && i_recover) begin
      assert (ckpt_dist(r_head, i_recover_id) < r_count);
      assert (!(i_retire && (r_count != '0) && (i_recover_id == r_head)));
    end
  end
endmodule

// File: rtl/map_table_ckpt.sv
// Multi-lane register rename map with intra-bundle forwarding, per-PR ready bits
// fed by the CDB, and a ring of map snapshots for single-cycle branch recovery.
module map_table_ckpt
  import sys_defs::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  map_table_input_t  [WAY-1:0]         dispatch_input,
  input  phy_reg_idx_t      [WAY-1:0]         free_tag,
  output map_table_output_t [WAY-1:0]         dispatch_output,
  output phy_reg_idx_t      [WAY-1:0]         Told_out,
  input  logic              [CDB_WIDTH-1:0]   cdb_valid,
  input  phy_reg_idx_t      [CDB_WIDTH-1:0]   cdb_tag,
  input  logic                                ckpt_req,
  input  logic              [LANE_W-1:0]      ckpt_lane,
  output ckpt_idx_t                           ckpt_id,
  output logic                                ckpt_full,
  input  logic                                ckpt_retire,
  input  logic                                recover_valid,
  input  ckpt_idx_t                           recover_id
);
  phy_reg_idx_t        r_map  [ARCH_REGS];
  phy_reg_idx_t        r_snap [NUM_CKPT][ARCH_REGS];
  logic [PHY_REGS-1:0] r_ready;

  phy_reg_idx_t        w_view     [ARCH_REGS];
  phy_reg_idx_t        w_snap_map [ARCH_REGS];
  logic [ARCH_REGS-1:0] w_fwd;
  logic [PHY_REGS-1:0] w_ready_nxt;
  logic                w_alloc_ok;

  function automatic logic f_src_ready(phy_reg_idx_t tag, logic [PHY_REGS-1:0] rdy,
                                       logic [CDB_WIDTH-1:0] cv,
                                       phy_reg_idx_t [CDB_WIDTH-1:0] ct);
    logic r;
    r = rdy[tag];
    for (int c = 0; c < CDB_WIDTH; c++)
      if (cv[c] && (ct[c] == tag)) r = 1'b1;
    return r;
  endfunction

  map_ckpt_ctrl u_ctrl (
    .clock        (clock),
    .reset        (reset),
    .i_alloc_req  (ckpt_req),
    .i_retire     (ckpt_retire),
    .i_recover    (recover_valid),
    .i_recover_id (recover_id),
    .o_alloc_id   (ckpt_id),
    .o_full       (ckpt_full),
    .o_alloc_ok   (w_alloc_ok)
  );

  // w_view walks the bundle lane by lane; a set w_fwd bit means the mapping was
  // produced earlier in this bundle, so its value cannot be ready yet.
  always_comb begin
    logic v_ren;
    w_view          = r_map;
    w_snap_map      = r_map;
    w_fwd           = '0;
    w_ready_nxt     = r_ready;
    dispatch_output = '0;
    Told_out        = '0;
    for (int c = 0; c < CDB_WIDTH; c++)
      if (cdb_valid[c]) w_ready_nxt[cdb_tag[c]] = 1'b1;
    for (int k = 0; k < WAY; k++) begin
      v_ren = dispatch_input[k].valid && (dispatch_input[k].rd != '0);
      if (dispatch_input[k].rs1 == '0) begin
        dispatch_output[k].rs1_tag = '0;
        dispatch_output[k].rs1_rdy = 1'b1;
      end else begin
        dispatch_output[k].rs1_tag = w_view[dispatch_input[k].rs1];
        dispatch_output[k].rs1_rdy = !w_fwd[dispatch_input[k].rs1] &&
          f_src_ready(w_view[dispatch_input[k].rs1], r_ready, cdb_valid, cdb_tag);
      end
      if (dispatch_input[k].rs2 == '0) begin
        dispatch_output[k].rs2_tag = '0;
        dispatch_output[k].rs2_rdy = 1'b1;
      end else begin
        dispatch_output[k].rs2_tag = w_view[dispatch_input[k].rs2];
        dispatch_output[k].rs2_rdy = !w_fwd[dispatch_input[k].rs2] &&
          f_src_ready(w_view[dispatch_input[k].rs2], r_ready, cdb_valid, cdb_tag);
      end
      if (v_ren) begin
        Told_out[k]                  = w_view[dispatch_input[k].rd];
        w_view[dispatch_input[k].rd] = free_tag[k];
        w_fwd[dispatch_input[k].rd]  = 1'b1;
        if (!recover_valid) w_ready_nxt[free_tag[k]] = 1'b0;
      end
      if (LANE_W'(k) <= ckpt_lane) w_snap_map = w_view;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) r_map[i] <= phy_reg_idx_t'(i);
      r_ready <= '1;
    end else begin
      if (recover_valid) r_map <= r_snap[recover_id];
      else               r_map <= w_view;
      r_ready <= w_ready_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (w_alloc_ok) r_snap[ckpt_id] <= w_snap_map;
  end
endmodule

// File: tb/tb_map_table_ckpt.sv
// Directed bench for map_table_ckpt: expectations are queued with each cycle's
// stimulus and compared against the combinational outputs before the next edge.
module tb_map_table_ckpt;
  import sys_defs::*;

  logic                              clock = 1'b0;
  logic                              reset;
  map_table_input_t  [WAY-1:0]       dispatch_input;
  phy_reg_idx_t      [WAY-1:0]       free_tag;
  map_table_output_t [WAY-1:0]       dispatch_output;
  phy_reg_idx_t      [WAY-1:0]       Told_out;
  logic              [CDB_WIDTH-1:0] cdb_valid;
  phy_reg_idx_t      [CDB_WIDTH-1:0] cdb_tag;
  logic                              ckpt_req;
  logic              [LANE_W-1:0]    ckpt_lane;
  ckpt_idx_t                         ckpt_id;
  logic                              ckpt_full;
  logic                              ckpt_retire;
  logic                              recover_valid;
  ckpt_idx_t                         recover_id;

  map_table_ckpt dut (
    .clock(clock), .reset(reset),
    .dispatch_input(dispatch_input), .free_tag(free_tag),
    .dispatch_output(dispatch_output), .Told_out(Told_out),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .ckpt_req(ckpt_req), .ckpt_lane(ckpt_lane),
    .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_retire(ckpt_retire), .recover_valid(recover_valid), .recover_id(recover_id)
  );

  always #5 clock = ~clock;

  localparam int K_T1 = 0, K_R1 = 1, K_T2 = 2, K_R2 = 3, K_TOLD = 4, K_ID = 5, K_FULL = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(int sel);
    int l;
    l = sel % 8;
    case (sel / 8)
      K_T1:    return 32'(dispatch_output[l].rs1_tag);
      K_R1:    return 32'(dispatch_output[l].rs1_rdy);
      K_T2:    return 32'(dispatch_output[l].rs2_tag);
      K_R2:    return 32'(dispatch_output[l].rs2_rdy);
      K_TOLD:  return 32'(Told_out[l]);
      K_ID:    return 32'(ckpt_id);
      default: return 32'(ckpt_full);
    endcase
  endfunction

  task automatic push(string tag, int kind, int l, int exp);
    sb_t e;
    e.tag = $sformatf("%s_L%0d@%0t", tag, l, $time);
    e.sel = kind * 8 + l;
    e.exp = 32'(exp);
    sb_q.push_back(e);
  endtask

  task automatic exp_lane(int l, int t1, int r1, int t2, int r2, int told);
    push("rs1_tag", K_T1, l, t1);
    push("rs1_rdy", K_R1, l, r1);
    push("rs2_tag", K_T2, l, t2);
    push("rs2_rdy", K_R2, l, r2);
    push("told", K_TOLD, l, told);
  endtask

  task automatic exp_ckpt(int id, int full);
    push("ckpt_id", K_ID, 0, id);
    push("ckpt_full", K_FULL, 0, full);
  endtask

  task automatic idle();
    dispatch_input = '0;
    free_tag       = '0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    ckpt_req       = 1'b0;
    ckpt_lane      = '0;
    ckpt_retire    = 1'b0;
    recover_valid  = 1'b0;
    recover_id     = '0;
  endtask

  task automatic lane(int l, bit v, int rs1, int rs2, int rd, int ft);
    dispatch_input[l].valid = v;
    dispatch_input[l].rs1   = arch_reg_idx_t'(rs1);
    dispatch_input[l].rs2   = arch_reg_idx_t'(rs2);
    dispatch_input[l].rd    = arch_reg_idx_t'(rd);
    free_tag[l]             = phy_reg_idx_t'(ft);
  endtask

  task automatic cdb(int c, int tag);
    cdb_valid[c] = 1'b1;
    cdb_tag[c]   = phy_reg_idx_t'(tag);
  endtask

  task automatic step();
    sb_t e;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.exp);
    end
    @(posedge clock);
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Plain lookup after reset plus forwarding into a lane with rd=0.
    lane(0, 1, 5, 6, 7, 33);
    lane(1, 1, 7, 0, 0, 34);
    exp_lane(0, 5, 1, 6, 1, 7);
    exp_lane(1, 33, 0, 0, 1, 0);
    exp_lane(2, 0, 1, 0, 1, 0);
    exp_ckpt(0, 0);
    step();
    lane(0, 1, 7, 0, 0, 0);
    exp_lane(0, 33, 0, 0, 1, 0);
    step();
    lane(0, 1, 7, 0, 0, 0); cdb(1, 33);
    exp_lane(0, 33, 1, 0, 1, 0);
    step();
    lane(0, 1, 7, 0, 0, 0);
    exp_lane(0, 33, 1, 0, 1, 0);
    step();

    // Allocation beats a same-cycle broadcast of the same tag.
    lane(0, 1, 0, 0, 8, 44); cdb(0, 44);
    exp_lane(0, 0, 1, 0, 1, 8);
    step();
    lane(0, 1, 8, 0, 0, 0);
    exp_lane(0, 44, 0, 0, 1, 0);
    step();

    // Nearest older lane wins when several lanes write the same rd.
    lane(0, 1, 0, 0, 10, 30);
    lane(1, 1, 10, 0, 10, 31);
    lane(2, 1, 10, 10, 10, 32);
    exp_lane(0, 0, 1, 0, 1, 10);
    exp_lane(1, 30, 0, 0, 1, 30);
    exp_lane(2, 31, 0, 31, 0, 31);
    step();
    lane(0, 1, 10, 0, 0, 0);
    exp_lane(0, 32, 0, 0, 1, 0);
    step();

    // Checkpoint after lane 0 only, then rename further and recover.
    lane(0, 1, 0, 0, 3, 40);
    lane(1, 1, 3, 0, 3, 41);
    ckpt_req = 1'b1; ckpt_lane = '0;
    exp_lane(0, 0, 1, 0, 1, 3);
    exp_lane(1, 40, 0, 0, 1, 40);
    exp_ckpt(0, 0);
    step();
    lane(0, 1, 3, 0, 3, 50);
    exp_lane(0, 41, 0, 0, 1, 41);
    exp_ckpt(1, 0);
    step();
    lane(0, 1, 3, 0, 0, 0);
    exp_lane(0, 50, 0, 0, 1, 0);
    step();
    recover_valid = 1'b1; recover_id = '0;
    lane(0, 1, 0, 0, 9, 60);
    ckpt_req = 1'b1;
    step();
    lane(0, 1, 3, 9, 0, 0);
    exp_lane(0, 40, 0, 9, 1, 0);
    exp_ckpt(1, 0);
    step();
    lane(0, 1, 3, 0, 0, 0); cdb(2, 40);
    exp_lane(0, 40, 1, 0, 1, 0);
    step();
    lane(0, 1, 3, 0, 0, 0);
    exp_lane(0, 40, 1, 0, 1, 0);
    step();

    // Reset with live traffic on the inputs.
    reset = 1'b1;
    lane(0, 1, 0, 0, 3, 55);
    ckpt_req = 1'b1;
    step();
    reset = 1'b0;
    lane(0, 1, 3, 10, 0, 0);
    exp_lane(0, 3, 1, 10, 1, 0);
    exp_ckpt(0, 0);
    step();

    // Fill the ring, request while full, then retire.
    for (int i = 0; i < NUM_CKPT; i++) begin
      ckpt_req = 1'b1;
      exp_ckpt(i, 0);
      step();
    end
    ckpt_req = 1'b1;
    exp_ckpt(0, 1);
    step();
    ckpt_retire = 1'b1;
    exp_ckpt(0, 1);
    step();
    ckpt_req = 1'b1;
    exp_ckpt(0, 0);
    step();

    // Recovery truncates younger checkpoints.
    reset = 1'b1;
    step();
    reset = 1'b0;
    lane(0, 1, 0, 0, 4, 20); ckpt_req = 1'b1;
    exp_lane(0, 0, 1, 0, 1, 4);
    exp_ckpt(0, 0);
    step();
    lane(0, 1, 4, 0, 4, 21); ckpt_req = 1'b1;
    exp_lane(0, 20, 0, 0, 1, 20);
    exp_ckpt(1, 0);
    step();
    lane(0, 1, 4, 0, 4, 22); ckpt_req = 1'b1;
    exp_lane(0, 21, 0, 0, 1, 21);
    exp_ckpt(2, 0);
    step();
    recover_valid = 1'b1; recover_id = ckpt_idx_t'(1);
    step();
    lane(0, 1, 4, 0, 0, 0); ckpt_req = 1'b1;
    exp_lane(0, 21, 0, 0, 1, 0);
    exp_ckpt(2, 0);
    step();
    ckpt_req = 1'b1;
    exp_ckpt(3, 0);
    step();
    exp_ckpt(0, 1);
    step();

    // Retire and recover in the same cycle.
    ckpt_retire = 1'b1; recover_valid = 1'b1; recover_id = ckpt_idx_t'(2);
    step();
    lane(0, 1, 4, 0, 0, 0); ckpt_req = 1'b1;
    exp_lane(0, 21, 0, 0, 1, 0);
    exp_ckpt(3, 0);
    step();
    ckpt_req = 1'b1;
    exp_ckpt(0, 0);
    step();
    exp_ckpt(1, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
